// File: rtl/tick_generator_if.sv
// Bundles the control inputs and tick/status outputs of tick_generator.
// The master side (system/testbench) drives pause and divisor loads.
// The slave side (tick_generator) drives the ticks, squares and status.
interface tick_generator_if #(
    parameter int GAME_DIV_W = 28
);

    logic                  pause;
    logic                  div_load;
    logic [GAME_DIV_W-1:0] div_value;

    logic                  display_tick;
    logic                  debounce_tick;
    logic                  game_tick;
    logic                  display_clk;
    logic                  debounce_clk;
    logic                  blink;
    logic [GAME_DIV_W-1:0] cur_div;
    logic                  load_err;

    modport master (
        output pause,
        output div_load,
        output div_value,
        input  display_tick,
        input  debounce_tick,
        input  game_tick,
        input  display_clk,
        input  debounce_clk,
        input  blink,
        input  cur_div,
        input  load_err
    );

    modport slave (
        input  pause,
        input  div_load,
        input  div_value,
        output display_tick,
        output debounce_tick,
        output game_tick,
        output display_clk,
        output debounce_clk,
        output blink,
        output cur_div,
        output load_err
    );

endinterface

// File: rtl/tick_generator.sv
// Clock-enable tick generator for the display mux, debouncers and game FSM.
// Display and debounce rates are fixed by parameters. The game rate comes
// from a runtime-loadable divisor, can be paused, and drives a blink output
// that toggles on every game tick. Every output is a flop in the clk domain.
module tick_generator #(
    parameter int DISP_DIV     = 4,
    parameter int DEB_DIV      = 131072,
    parameter int GAME_DIV_W   = 28,
    parameter int GAME_DIV_RST = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    tick_generator_if.slave bus
);

    // Counter widths sized so each channel just holds 0..DIV-1.
    localparam int DISP_W = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
    localparam int DEB_W  = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    localparam logic [DISP_W-1:0]     DISP_LAST = DISP_W'(DISP_DIV - 1);
    localparam logic [DISP_W-1:0]     DISP_HALF = DISP_W'(DISP_DIV / 2);
    localparam logic [DEB_W-1:0]      DEB_LAST  = DEB_W'(DEB_DIV - 1);
    localparam logic [DEB_W-1:0]      DEB_HALF  = DEB_W'(DEB_DIV / 2);
    localparam logic [GAME_DIV_W-1:0] GAME_RST  = GAME_DIV_W'(GAME_DIV_RST);
    localparam logic [GAME_DIV_W-1:0] GAME_MIN  = GAME_DIV_W'(2);
    localparam logic [GAME_DIV_W-1:0] GAME_ONE  = GAME_DIV_W'(1);

    // A divisor below 2 cannot produce a separate tick cycle, so refuse it.
    if (DISP_DIV < 2) begin : g_bad_disp_div
        $error("tick_generator: DISP_DIV must be at least 2");
    end
    if (DEB_DIV < 2) begin : g_bad_deb_div
        $error("tick_generator: DEB_DIV must be at least 2");
    end
    if (GAME_DIV_W < 2 || GAME_DIV_W > 62) begin : g_bad_game_w
        $error("tick_generator: GAME_DIV_W must be within 2..62");
    end
    if (GAME_DIV_RST < 2 ||
        longint'(GAME_DIV_RST) >= (longint'(1) << GAME_DIV_W)) begin : g_bad_game_rst
        $error("tick_generator: GAME_DIV_RST must be >= 2 and fit in GAME_DIV_W bits");
    end

    logic [DISP_W-1:0]     disp_cnt_q, disp_cnt_d;
    logic                  disp_tick_q, disp_tick_d;
    logic                  disp_clk_q, disp_clk_d;

    logic [DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
    logic                  deb_tick_q, deb_tick_d;
    logic                  deb_clk_q, deb_clk_d;

    logic [GAME_DIV_W-1:0] game_cnt_q, game_cnt_d;
    logic [GAME_DIV_W-1:0] cur_div_q, cur_div_d;
    logic                  game_tick_q, game_tick_d;
    logic                  blink_q, blink_d;
    logic                  load_err_q, load_err_d;

    logic                  game_wrap;
    logic                  load_ok;

    // Display channel: wrap at DISP_DIV-1; tick marks the wrap, square follows next count.
    always_comb begin
        disp_cnt_d  = disp_cnt_q + DISP_W'(1);
        disp_tick_d = 1'b0;
        if (disp_cnt_q == DISP_LAST) begin
            disp_cnt_d  = '0;
            disp_tick_d = 1'b1;
        end
        disp_clk_d = (disp_cnt_d >= DISP_HALF);
    end

    // Debounce channel: same scheme as the display channel with its own period.
    always_comb begin
        deb_cnt_d  = deb_cnt_q + DEB_W'(1);
        deb_tick_d = 1'b0;
        if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_d  = '0;
            deb_tick_d = 1'b1;
        end
        deb_clk_d = (deb_cnt_d >= DEB_HALF);
    end

    assign game_wrap = (game_cnt_q == (cur_div_q - GAME_ONE));
    assign load_ok   = bus.div_load && (bus.div_value >= GAME_MIN);

    // Game channel: a valid load restarts the period and beats a coincident wrap;
    // a rejected load only flags load_err and lets counting carry on; pause freezes.
    always_comb begin
        game_cnt_d  = game_cnt_q;
        cur_div_d   = cur_div_q;
        game_tick_d = 1'b0;
        blink_d     = blink_q;
        load_err_d  = bus.div_load && !load_ok;
        if (load_ok) begin
            cur_div_d  = bus.div_value;
            game_cnt_d = '0;
        end else if (!bus.pause) begin
            if (game_wrap) begin
                game_cnt_d  = '0;
                game_tick_d = 1'b1;
                blink_d     = !blink_q;
            end else begin
                game_cnt_d = game_cnt_q + GAME_ONE;
            end
        end
    end

    // Display and debounce state; reset restarts both periods from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_cnt_q  <= '0;
            disp_tick_q <= 1'b0;
            disp_clk_q  <= 1'b0;
            deb_cnt_q   <= '0;
            deb_tick_q  <= 1'b0;
            deb_clk_q   <= 1'b0;
        end else begin
            disp_cnt_q  <= disp_cnt_d;
            disp_tick_q <= disp_tick_d;
            disp_clk_q  <= disp_clk_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_tick_q  <= deb_tick_d;
            deb_clk_q   <= deb_clk_d;
        end
    end

    // Game state; reset restores the power-on divisor and clears blink and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            game_cnt_q  <= '0;
            cur_div_q   <= GAME_RST;
            game_tick_q <= 1'b0;
            blink_q     <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            game_cnt_q  <= game_cnt_d;
            cur_div_q   <= cur_div_d;
            game_tick_q <= game_tick_d;
            blink_q     <= blink_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.display_tick  = disp_tick_q;
    assign bus.debounce_tick = deb_tick_q;
    assign bus.game_tick     = game_tick_q;
    assign bus.display_clk   = disp_clk_q;
    assign bus.debounce_clk  = deb_clk_q;
    assign bus.blink         = blink_q;
    assign bus.cur_div       = cur_div_q;
    assign bus.load_err      = load_err_q;

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator with DISP_DIV=4, DEB_DIV=8,
// GAME_DIV_RST=5, GAME_DIV_W=8. A behavioural model predicts every output
// from elapsed-cycle arithmetic and the game divisor rules.
module tb_tick_generator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    tick_generator_if #(.GAME_DIV_W(W)) bus();

    tick_generator #(
        .DISP_DIV    (4),
        .DEB_DIV     (8),
        .GAME_DIV_W  (W),
        .GAME_DIV_RST(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int passed = 0;
    int total  = 0;

    // Model state: cycles since reset release, game progress within the period.
    int m_t     = 0;
    int m_phase = 0;
    int m_div   = 5;
    bit m_tick  = 1'b0;
    bit m_blink = 1'b0;
    bit m_err   = 1'b0;

    // Clock one edge, update the model from the inputs seen at that edge, then settle.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_t = 0; m_phase = 0; m_div = 5;
            m_tick = 1'b0; m_blink = 1'b0; m_err = 1'b0;
        end else begin
            m_t++;
            m_tick = 1'b0;
            m_err  = bus.div_load && (int'(bus.div_value) < 2);
            if (bus.div_load && int'(bus.div_value) >= 2) begin
                m_div   = int'(bus.div_value);
                m_phase = 0;
            end else if (!bus.pause) begin
                m_phase++;
                if (m_phase == m_div) begin
                    m_phase = 0;
                    m_tick  = 1'b1;
                    m_blink = !m_blink;
                end
            end
        end
        #1;
    endtask

    function automatic logic [14:0] expected();
        return {(m_t > 0) && (m_t % 4 == 0), (m_t > 0) && (m_t % 8 == 0), m_tick,
                (m_t % 4) >= 2, (m_t % 8) >= 4, m_blink, m_err, W'(m_div)};
    endfunction

    function automatic logic [14:0] observed();
        return {bus.display_tick, bus.debounce_tick, bus.game_tick, bus.display_clk,
                bus.debounce_clk, bus.blink, bus.load_err, bus.cur_div};
    endfunction

    task automatic do_reset();
        bus.pause = 1'b0; bus.div_load = 1'b0; bus.div_value = '0;
        rst = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.pause = 1'b1; bus.div_load = 1'b1; bus.div_value = W'(9);
        rst = 1'b1;
        advance();
        total++;
        if (observed() !== {7'b0, W'(5)}) $display("FAIL reset: got %h need %h", observed(), {7'b0, W'(5)});
        else passed++;
        rst = 1'b0; bus.pause = 1'b0; bus.div_load = 1'b0;
    endtask

    task automatic test_free_run();
        int ticks[$];
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            advance();
            if (bus.game_tick) ticks.push_back(m_t * 2 + int'(bus.blink));
            total++;
            if (observed() !== expected()) $display("FAIL free_run cycle %0d: got %h need %h", m_t, observed(), expected());
            else passed++;
        end
        total++;
        if (ticks.size() != 2 || ticks[0] != 11 || ticks[1] != 20)
            $display("FAIL free_run_game_ticks: got %p need '{11,20} (cycle*2+blink)", ticks);
        else passed++;
    endtask

    task automatic test_pause();
        int ticks[$];
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            bus.pause = (m_t >= 7 && m_t <= 13);
            advance();
            if (bus.game_tick) ticks.push_back(m_t);
            total++;
            if (observed() !== expected()) $display("FAIL pause cycle %0d: got %h need %h", m_t, observed(), expected());
            else passed++;
        end
        bus.pause = 1'b0;
        total++;
        if (ticks.size() != 2 || ticks[0] != 5 || ticks[1] != 17)
            $display("FAIL pause_game_ticks: got %p need '{5,17}", ticks);
        else passed++;
    endtask

    task automatic test_load();
        int ticks[$];
        do_reset();
        for (int c = 1; c <= 32; c++) begin
            bus.div_load  = (m_t == 20);
            bus.div_value = W'(3);
            advance();
            if (bus.game_tick && m_t > 20) ticks.push_back(m_t);
            total++;
            if (observed() !== expected()) $display("FAIL load cycle %0d: got %h need %h", m_t, observed(), expected());
            else passed++;
        end
        bus.div_load = 1'b0;
        total++;
        if (ticks.size() != 3 || ticks[0] != 24 || ticks[1] != 27 || ticks[2] != 30)
            $display("FAIL load_game_ticks: got %p need '{24,27,30}", ticks);
        else passed++;
    endtask

    task automatic test_bad_load();
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            bus.div_load  = (m_t == 3 || m_t == 7);
            bus.div_value = W'($urandom_range(0, 1));
            advance();
            total++;
            if (observed() !== expected()) $display("FAIL bad_load cycle %0d: got %h need %h", m_t, observed(), expected());
            else passed++;
        end
        bus.div_load = 1'b0;
    endtask

    task automatic test_load_on_wrap();
        int wait_cycles = 0;
        int gap = 0;
        do_reset();
        advance();
        while (m_phase != m_div - 1 && wait_cycles < 20) begin
            advance();
            wait_cycles++;
        end
        bus.div_load = 1'b1; bus.div_value = W'(4);
        advance();
        bus.div_load = 1'b0;
        total++;
        if (bus.game_tick !== 1'b0 || bus.cur_div !== W'(4))
            $display("FAIL load_on_wrap_edge: got tick %b div %0d need tick 0 div 4", bus.game_tick, bus.cur_div);
        else passed++;
        do begin
            advance();
            gap++;
        end while (!bus.game_tick && gap < 10);
        total++;
        if (gap != 4) $display("FAIL load_on_wrap_gap: got %0d cycles need 4", gap);
        else passed++;
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 13; c++) advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        total++;
        if (observed() !== {7'b0, W'(5)}) $display("FAIL mid_reset: got %h need %h", observed(), {7'b0, W'(5)});
        else passed++;
        for (int c = 1; c <= 12; c++) begin
            advance();
            total++;
            if (observed() !== expected()) $display("FAIL mid_reset_rerun cycle %0d: got %h need %h", m_t, observed(), expected());
            else passed++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.pause     = ($urandom_range(0, 4) == 0);
            bus.div_load  = ($urandom_range(0, 9) == 0);
            bus.div_value = W'($urandom_range(0, 12));
            rst           = ($urandom_range(0, 99) == 0);
            advance();
            total++;
            if (observed() !== expected()) $display("FAIL random step %0d: got %h need %h", c, observed(), expected());
            else passed++;
        end
        rst = 1'b0; bus.pause = 1'b0; bus.div_load = 1'b0;
    endtask

    initial begin
        $display("[TB] tick_generator bench starting");
        test_reset();
        test_free_run();
        test_pause();
        test_load();
        test_bad_load();
        test_load_on_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
